// File: rtl/fetch_unit.sv
// Purpose: sequential instruction fetch with an in-order slot queue and redirect flush.
// Latency: request issue is combinational from state; a response at edge N is visible as inst_valid in cycle N+1.
// Backpressure: requests stall while DEPTH slots are allocated; a stalled consumer holds the head until it pops.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    // Slot index width, pointer width (extra MSB distinguishes full from
    // empty) and drop counter width. The drop counter gets two spare bits:
    // back-to-back redirects can stack several queues' worth of unfilled
    // requests before the memory returns them.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = AW + 3;

    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]  head_q,     head_d;
    logic [PW-1:0]  fill_q,     fill_d;
    logic [PW-1:0]  alloc_q,    alloc_d;
    logic [DW-1:0]  drop_cnt_q, drop_cnt_d;

    logic [31:0]      slot_pc_q     [DEPTH];
    logic [31:0]      slot_pc_d     [DEPTH];
    logic [31:0]      slot_data_q   [DEPTH];
    logic [31:0]      slot_data_d   [DEPTH];
    logic [DEPTH-1:0] slot_filled_q;
    logic [DEPTH-1:0] slot_filled_d;

    // ------------------------------------------------------------------
    // Derived occupancy and handshakes
    // ------------------------------------------------------------------
    logic [PW-1:0] allocated;
    logic [PW-1:0] unfilled;
    logic [AW-1:0] head_idx;
    logic [AW-1:0] fill_idx;
    logic [AW-1:0] alloc_idx;
    logic          req_fire;
    logic          pop_fire;
    logic [DW-1:0] drop_sum;

    // Low address bits of a redirect target are discarded by design.
    logic unused_redirect_lo;
    assign unused_redirect_lo = ^redirect_pc[1:0];

    assign allocated = alloc_q - head_q;
    assign unfilled  = alloc_q - fill_q;
    assign head_idx  = head_q[AW-1:0];
    assign fill_idx  = fill_q[AW-1:0];
    assign alloc_idx = alloc_q[AW-1:0];

    // A redirect suppresses the request so the stale fetch_pc never leaves.
    assign imem_req_valid = rst && (allocated < DEPTH_P) && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;

    // The head is only presented once its response has landed in the slot;
    // there is no bypass from imem_rsp_data to inst_out.
    assign inst_valid = slot_filled_q[head_idx] && (allocated != '0);
    assign inst_out   = slot_data_q[head_idx];
    assign inst_pc    = slot_pc_q[head_idx];

    assign req_fire = imem_req_valid && imem_req_ready;
    assign pop_fire = inst_valid && inst_ready;

    // Next-state: redirect wins outright, otherwise pop/response/request
    // all apply in the same cycle. They never touch the same slot: a pop
    // needs a filled head, a response targets an unfilled slot, and a
    // request targets a free slot.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        head_d        = head_q;
        fill_d        = fill_q;
        alloc_d       = alloc_q;
        drop_cnt_d    = drop_cnt_q;
        slot_pc_d     = slot_pc_q;
        slot_data_d   = slot_data_q;
        slot_filled_d = slot_filled_q;
        drop_sum      = drop_cnt_q + DW'(unfilled);

        if (redirect_valid) begin
            // Everything still owed by the memory for the old stream becomes
            // a pending drop; a response arriving right now is itself one of
            // them and is discarded on the spot. A pop this cycle already
            // completed from the consumer's point of view.
            if (imem_rsp_valid && (drop_sum != '0)) begin
                drop_sum = drop_sum - DW'(1);
            end
            fetch_pc_d    = {redirect_pc[31:2], 2'b00};
            head_d        = '0;
            fill_d        = '0;
            alloc_d       = '0;
            slot_filled_d = '0;
            drop_cnt_d    = drop_sum;
        end else begin
            if (pop_fire) begin
                head_d                  = head_q + PW'(1);
                slot_filled_d[head_idx] = 1'b0;
            end

            if (imem_rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - DW'(1);
                end else if (unfilled != '0) begin
                    slot_data_d[fill_idx]   = imem_rsp_data;
                    slot_filled_d[fill_idx] = 1'b1;
                    fill_d                  = fill_q + PW'(1);
                end
            end

            if (req_fire) begin
                slot_pc_d[alloc_idx]     = fetch_pc_q;
                slot_filled_d[alloc_idx] = 1'b0;
                alloc_d                  = alloc_q + PW'(1);
                fetch_pc_d               = fetch_pc_q + 32'd4;
            end
        end
    end

    // State registers; reset clears every slot so outputs read zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            head_q        <= '0;
            fill_q        <= '0;
            alloc_q       <= '0;
            drop_cnt_q    <= '0;
            slot_filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc_q[i]   <= '0;
                slot_data_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            head_q        <= head_d;
            fill_q        <= fill_d;
            alloc_q       <= alloc_d;
            drop_cnt_q    <= drop_cnt_d;
            slot_filled_q <= slot_filled_d;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc_q[i]   <= slot_pc_d[i];
                slot_data_q[i] <= slot_data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with per-request latency,
// a PC scoreboard filled at request handshake and drained at pop,
// and directed steps for reset, full queue, redirect and mid-stream reset.
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] pop_log[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          last_due = 0;
    int          req_cnt  = 0;
    int          pop_cnt  = 0;
    logic [31:0] ref_pc   = RESET_PC;
    logic [31:0] last_req_addr = 32'h0;
    logic        saw_wrap = 1'b0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'd3) + 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // In-order memory: each accepted request returns no earlier than its
    // latency and never before the one ahead of it.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // Mid-cycle observer: request/pop handshakes and redirects.
    always @(negedge clk) begin
        if (rst) begin
            if (inst_valid && inst_ready) begin
                pop_cnt++;
                pop_log.push_back(inst_pc);
                check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("inst_pc", inst_pc, e);
                    check("inst_out", inst_out, mem_data(e));
                end
            end
            if (redirect_valid) begin
                check("no_req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
                exp_q.delete();
                ref_pc = {redirect_pc[31:2], 2'b00};
            end else if (imem_req_valid && imem_req_ready) begin
                int due;
                check("req_addr", imem_req_addr, ref_pc);
                if (last_req_addr == 32'hFFFF_FFFC && imem_req_addr == 32'h0) saw_wrap = 1'b1;
                last_req_addr = imem_req_addr;
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{addr: imem_req_addr, due: due});
                exp_q.push_back(ref_pc);
                ref_pc = ref_pc + 32'd4;
                req_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hs0;
        int p0;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        #1;
        rst = 1'b0;
        #2;
        // Reset state
        check("rst_req_valid",  {31'b0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid},     32'd0);
        check("rst_inst_out",   inst_out,      32'h0);
        check("rst_inst_pc",    inst_pc,       32'h0);
        check("rst_req_addr",   imem_req_addr, RESET_PC);

        // Release, stream with 1-cycle latency
        step(2);
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 1;
        @(negedge clk);
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_req_addr",  imem_req_addr, 32'h0);
        @(negedge clk);
        check("second_req_addr", imem_req_addr, 32'h4);
        check("no_inst_yet",     {31'b0, inst_valid}, 32'd0);
        @(negedge clk);
        check("first_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("first_inst_pc",    inst_pc,  32'h0);
        check("first_inst_out",   inst_out, 32'h0000_0013);
        step(6);

        // Full queue: consumer stalled
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step(1);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        hs0 = req_cnt;
        @(negedge clk);
        check("redir_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("redir_req_addr",  imem_req_addr, 32'h0);
        check("redir_inst_off",  {31'b0, inst_valid}, 32'd0);
        step(8);
        @(negedge clk);
        check("full_req_count", req_cnt - hs0, 32'd4);
        check("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("full_head_pc",   inst_pc, 32'h0);
        step(1);
        inst_ready = 1'b1;
        hs0 = req_cnt;
        step(1);
        inst_ready = 1'b0;
        step(5);
        @(negedge clk);
        check("refill_count", req_cnt - hs0, 32'd1);
        check("refill_addr",  last_req_addr, 32'h10);
        check("refill_full",  {31'b0, imem_req_valid}, 32'd0);

        // Redirect coinciding with the first of three responses
        step(1);
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step(1);
        redirect_valid = 1'b0;
        step(8);
        lat            = 3;
        imem_req_ready = 1'b1;
        step(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        pop_log.delete();
        @(negedge clk);
        check("c_rsp_in_redirect", {31'b0, imem_rsp_valid}, 32'd1);
        step(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("c_req_addr",   imem_req_addr, 32'h100);
        check("c_req_valid",  {31'b0, imem_req_valid}, 32'd1);
        check("c_inst_off",   {31'b0, inst_valid}, 32'd0);
        step(10);
        check("c_first_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);

        // Redirect while popping a two-entry queue
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        lat            = 1;
        step(1);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        step(2);
        imem_req_ready = 1'b0;
        step(10);
        @(negedge clk);
        check("d_head_valid", {31'b0, inst_valid}, 32'd1);
        check("d_head_pc",    inst_pc, 32'h40);
        step(1);
        pop_log.delete();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step(1);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("d_inst_off",  {31'b0, inst_valid}, 32'd0);
        check("d_pop_count", pop_log.size(), 32'd1);
        check("d_pop_pc",    pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF, 32'h40);
        check("d_req_addr",  imem_req_addr, 32'h80);

        // Random traffic with redirects, including a wrap past 0xFFFFFFFC
        step(1);
        p0 = pop_cnt;
        for (int i = 0; i < 1500; i++) begin
            imem_req_ready = ($urandom % 10) < 7;
            inst_ready     = ($urandom % 10) < 7;
            lat            = $urandom_range(1, 4);
            redirect_valid = 1'b0;
            if (i == 200) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'hFFFF_FFF1;
            end else if ((i < 200 || i > 240) && ($urandom % 40) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
            step(1);
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        step(40);
        @(negedge clk);
        check("e_no_lost",   exp_q.size(), 32'd0);
        check("e_mem_idle",  mq.size(), 32'd0);
        check("e_wrap_seen", {31'b0, saw_wrap}, 32'd1);
        check("e_progress",  {31'b0, (pop_cnt - p0) >= 200}, 32'd1);

        // Reset with responses still in flight
        step(1);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        lat            = 3;
        step(6);
        rst = 1'b0;
        exp_q.delete();
        mq.delete();
        ref_pc        = RESET_PC;
        last_req_addr = 32'h0;
        #1;
        check("f_req_valid",  {31'b0, imem_req_valid}, 32'd0);
        check("f_inst_valid", {31'b0, inst_valid},     32'd0);
        check("f_inst_out",   inst_out,      32'h0);
        check("f_inst_pc",    inst_pc,       32'h0);
        check("f_req_addr",   imem_req_addr, RESET_PC);
        step(2);
        rst        = 1'b1;
        inst_ready = 1'b1;
        lat        = 1;
        @(negedge clk);
        check("f_restart_valid", {31'b0, imem_req_valid}, 32'd1);
        check("f_restart_addr",  imem_req_addr, RESET_PC);
        step(20);
        imem_req_ready = 1'b0;
        step(15);
        @(negedge clk);
        check("f_no_lost", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
